// File: rtl/pdp8_pkg.sv
// Shared PDP-8 IOT definitions: sequencer states, bus phase codes,
// the internal interrupt device code and its function codes.
package pdp8_pkg;

  typedef enum logic [2:0] {IDLE, S_F0, S_F1, S_F2, S_F3} iot_state_e;

  localparam logic [3:0] F0 = 4'b0000;
  localparam logic [3:0] F1 = 4'b0001;
  localparam logic [3:0] F2 = 4'b0010;
  localparam logic [3:0] F3 = 4'b0011;

  localparam logic [5:0] DEV_INT = 6'o00;

  localparam logic [2:0] SKON = 3'o0;
  localparam logic [2:0] ION  = 3'o1;
  localparam logic [2:0] IOF  = 3'o2;

endpackage

// File: rtl/pdp8_iot_master_if.sv
// Shared IOT bus between the CPU-side master and the devices.
// PDP8_IOT_WAIT_EN adds the io_wait stall line.
interface pdp8_iot_master_if;
  logic [3:0]  state;
  logic        iot;
  logic [11:0] mb;
  logic [5:0]  io_select;
  logic        io_selected;
  logic        io_skip;
`ifdef PDP8_IOT_WAIT_EN
  logic        io_wait;

  modport master (output state, iot, mb, io_select,
                  input  io_selected, io_skip, io_wait);
  modport slave  (input  state, iot, mb, io_select,
                  output io_selected, io_skip, io_wait);
`else
  modport master (output state, iot, mb, io_select,
                  input  io_selected, io_skip);
  modport slave  (input  state, iot, mb, io_select,
                  output io_selected, io_skip);
`endif
endinterface

// File: rtl/pdp8_int_ctl.sv
// Interrupt system: ION delay (pend -> arm -> enable across two
// instruction ends), IOF, acknowledge, and the registered request.
module pdp8_int_ctl #(
  parameter int NDEV = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ion_stb,
  input  logic            iof_stb,
  input  logic            insn_done,
  input  logic            int_ack,
  input  logic [NDEV-1:0] io_interrupt,
  output logic            int_enable,
  output logic            int_req
);

  logic ion_pend;
  logic arm;

  always_ff @(posedge clk) begin
    if (reset) begin
      int_enable <= 1'b0;
      int_req    <= 1'b0;
      ion_pend   <= 1'b0;
      arm        <= 1'b0;
    end else if (int_ack) begin
      // Acknowledge overrides any ION/IOF strobe landing on the same edge.
      int_enable <= 1'b0;
      int_req    <= 1'b0;
      ion_pend   <= 1'b0;
      arm        <= 1'b0;
    end else begin
      int_req <= int_enable & (|io_interrupt);
      if (iof_stb) begin
        int_enable <= 1'b0;
        ion_pend   <= 1'b0;
        arm        <= 1'b0;
      end else if (ion_stb) begin
        ion_pend <= 1'b1;
      end else if (insn_done && ion_pend) begin
        if (arm) begin
          int_enable <= 1'b1;
          ion_pend   <= 1'b0;
          arm        <= 1'b0;
        end else begin
          arm <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pdp8_iot_master.sv
// CPU-side IOT bus sequencer (F0..F3) with the device-00 interrupt system.
// PDP8_IOT_WAIT_EN enables io_wait stalls in F1, bounded by WAIT_MAX.
//
//   state | meaning
//   IDLE  | no IOT in progress, bus idle
//   S_F0  | mb/io_select presented, iot asserted
//   S_F1  | device responses sampled (stalls on io_wait when enabled)
//   S_F2  | device-00 ION/IOF take effect
//   S_F3  | last phase; done pulses on the exit edge
module pdp8_iot_master
  import pdp8_pkg::*;
#(
  parameter int NDEV     = 8,
  parameter int WAIT_MAX = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [11:0]        instr,
  output logic               busy,
  output logic               done,
  output logic               skip,
  output logic               nodev,
  pdp8_iot_master_if.master  bus,
  input  logic [NDEV-1:0]    io_interrupt,
  input  logic               insn_done,
  output logic               int_enable,
  output logic               int_req,
  input  logic               int_ack
);

  iot_state_e  st, nxt;
  logic [11:0] mb;
  logic [3:0]  phase;
  logic        iot_w, sample, ion_stb, iof_stb;
  logic        sel_r, skp_r, dev_int;

  assign dev_int       = (mb[8:3] == DEV_INT);
  assign bus.mb        = mb;
  assign bus.io_select = mb[8:3];
  assign bus.state     = phase;
  assign bus.iot       = iot_w;

`ifdef PDP8_IOT_WAIT_EN
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             stall;

  assign stall = bus.io_wait && (wait_cnt != '0);

  // Down-counter loaded on F1 entry; reaching zero forces the advance.
  always_ff @(posedge clk) begin
    if (reset)             wait_cnt <= '0;
    else if (st == S_F0)   wait_cnt <= CNT_W'(WAIT_MAX);
    else if (stall && st == S_F1) wait_cnt <= wait_cnt - 1'b1;
  end
`else
  logic stall;
  logic unused_wait_max;
  assign stall           = 1'b0;
  assign unused_wait_max = (WAIT_MAX < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else       st <= nxt;
  end

  always_comb begin
    nxt     = st;
    busy    = 1'b1;
    iot_w   = 1'b1;
    phase   = F0;
    sample  = 1'b0;
    ion_stb = 1'b0;
    iof_stb = 1'b0;
    case (st)
      IDLE: begin
        busy  = 1'b0;
        iot_w = 1'b0;
        if (start) nxt = S_F0;
      end
      S_F0: nxt = S_F1;
      S_F1: begin
        phase  = F1;
        sample = 1'b1;
        if (!stall) nxt = S_F2;
      end
      S_F2: begin
        phase   = F2;
        ion_stb = dev_int && (mb[2:0] == ION);
        iof_stb = dev_int && (mb[2:0] == IOF);
        nxt     = S_F3;
      end
      S_F3: begin
        phase = F3;
        nxt   = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mb    <= '0;
      sel_r <= 1'b0;
      skp_r <= 1'b0;
      done  <= 1'b0;
      skip  <= 1'b0;
      nodev <= 1'b0;
    end else begin
      if (st == IDLE && start) mb <= instr;
      if (sample) begin
        sel_r <= bus.io_selected;
        // Device 00 is answered internally; only SKON can skip.
        skp_r <= dev_int ? ((mb[2:0] == SKON) && int_enable) : bus.io_skip;
      end
      done <= (st == S_F3);
      if (st == S_F3) begin
        skip  <= skp_r;
        nodev <= !dev_int && !sel_r;
      end
    end
  end

  pdp8_int_ctl #(.NDEV(NDEV)) u_int_ctl (
    .clk          (clk),
    .reset        (reset),
    .ion_stb      (ion_stb),
    .iof_stb      (iof_stb),
    .insn_done    (insn_done),
    .int_ack      (int_ack),
    .io_interrupt (io_interrupt),
    .int_enable   (int_enable),
    .int_req      (int_req)
  );

endmodule
